// File: rtl/mem_arbiter.sv
// Two-port memory bus arbiter: instruction fetch (I) and data (D) share one bus.
// D has priority; a starvation counter forces an I win after STARVE_MAX D grants.
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned CNT_W      = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_data,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic        d_write,
  input  logic [31:0] d_wdata,
  input  logic        d_extend,
  input  logic [1:0]  d_width,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        mem_write,
  output logic [31:0] mem_wdata,
  output logic        mem_extend,
  output logic [1:0]  mem_width,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        busy_d,
  output logic        busy_i
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  owner_t           r_owner;
  logic             r_orphan;
  logic [AW-1:0]    r_addr;
  logic             r_write;
  logic [DW-1:0]    r_wdata;
  logic             r_extend;
  logic [1:0]       r_width;
  logic [CNT_W-1:0] r_starve_cnt;

  logic w_idle;
  logic w_starved;
  logic w_win_i;
  logic w_win_d;
  logic w_owner_req;

  // Arbitration only happens while the bus is idle.
  always_comb begin
    w_idle      = (r_owner == OWN_NONE);
    w_starved   = (r_starve_cnt == CNT_W'(STARVE_MAX));
    w_win_i     = w_idle & i_req & (~d_req | w_starved);
    w_win_d     = w_idle & d_req & ~w_win_i;
    w_owner_req = ((r_owner == OWN_I) & i_req) | ((r_owner == OWN_D) & d_req);
  end

  // Bus drive: latch while owned, winner's live fields during a grant cycle.
  always_comb begin
    mem_req    = 1'b0;
    mem_addr   = '0;
    mem_write  = 1'b0;
    mem_wdata  = '0;
    mem_extend = 1'b0;
    mem_width  = 2'd0;
    if (!w_idle) begin
      mem_req    = 1'b1;
      mem_addr   = r_addr;
      mem_write  = r_write;
      mem_wdata  = r_wdata;
      mem_extend = r_extend;
      mem_width  = r_width;
    end else if (w_win_i) begin
      mem_req    = 1'b1;
      mem_addr   = i_addr;
      mem_width  = 2'd2;
    end else if (w_win_d) begin
      mem_req    = 1'b1;
      mem_addr   = d_addr;
      mem_write  = d_write;
      mem_wdata  = d_wdata;
      mem_extend = d_extend;
      mem_width  = d_width;
    end

    // An orphaned or withdrawn owner never sees its ack.
    i_ack  = mem_ack & (w_win_i | ((r_owner == OWN_I) & ~r_orphan & i_req));
    d_ack  = mem_ack & (w_win_d | ((r_owner == OWN_D) & ~r_orphan & d_req));
    busy_i = w_win_i | (r_owner == OWN_I);
    busy_d = w_win_d | (r_owner == OWN_D);

    if (!reset_n) begin
      mem_req = 1'b0;
      i_ack   = 1'b0;
      d_ack   = 1'b0;
      busy_i  = 1'b0;
      busy_d  = 1'b0;
    end
  end

  assign i_data  = mem_rdata;
  assign d_rdata = mem_rdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_owner      <= OWN_NONE;
      r_orphan     <= 1'b0;
      r_addr       <= '0;
      r_write      <= 1'b0;
      r_wdata      <= '0;
      r_extend     <= 1'b0;
      r_width      <= 2'd0;
      r_starve_cnt <= '0;
    end else if (w_idle) begin
      if (w_win_i) begin
        r_starve_cnt <= '0;
      end else if (w_win_d && i_req && !w_starved) begin
        r_starve_cnt <= r_starve_cnt + CNT_W'(1);
      end
      // Grants completed in the same cycle never take ownership.
      if ((w_win_i || w_win_d) && !mem_ack) begin
        r_owner  <= w_win_i ? OWN_I : OWN_D;
        r_addr   <= mem_addr;
        r_write  <= mem_write;
        r_wdata  <= mem_wdata;
        r_extend <= mem_extend;
        r_width  <= mem_width;
      end
    end else if (mem_ack) begin
      r_owner  <= OWN_NONE;
      r_orphan <= 1'b0;
    end else if (!w_owner_req) begin
      r_orphan <= 1'b1;
    end
  end

endmodule
